// File: rtl/multi_block_multiplier_if.sv
// multi_block_multiplier_if: request/result bus of the multi-block multiplier
interface multi_block_multiplier_if #(
    parameter int W = 64
);
    logic           start;
    logic [W-1:0]   indata_a;
    logic [W-1:0]   indata_b;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] outdata_r;
    modport master (output start, indata_a, indata_b, input busy, valid, outdata_r);
    modport slave  (input start, indata_a, indata_b, output busy, valid, outdata_r);
endinterface

// File: rtl/multi_block_multiplier.sv
// multi_block_multiplier: sequential schoolbook multiplier over 16-bit limbs; MULT_EARLY_ZERO_EN short-circuits zero operands
package multiplier_pkg;
    localparam int BLOCK_LENGTH = 16;
endpackage

module multiplier_16x16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) p_o <= '0;
        else p_o <= a_i * b_i;
endmodule

module multi_block_multiplier
    import multiplier_pkg::*;
#(
    parameter int NUM_BLOCKS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    multi_block_multiplier_if.slave bus
);
    localparam int BL = BLOCK_LENGTH;
    localparam int W  = NUM_BLOCKS * BL;
    localparam int IW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
    localparam int SW = $clog2(2 * NUM_BLOCKS);
    localparam logic [IW-1:0] LAST = IW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]    a_q, b_q;
    logic [IW-1:0]   i_q, j_q;
    logic [SW-1:0]   sh_q;
    logic            p_vld;
    logic [BL-1:0]   a_limb, b_limb;
    logic [2*BL-1:0] prod;
    logic [2*W-1:0]  acc, acc_sum, res_q;
    logic            early_zero, accept, last_pair;

`ifdef MULT_EARLY_ZERO_EN
    assign early_zero = (bus.indata_a == '0) || (bus.indata_b == '0);
`else
    assign early_zero = 1'b0;
`endif

    assign accept    = (state == IDLE) && bus.start;
    assign last_pair = (i_q == LAST) && (j_q == LAST);
    assign a_limb    = a_q[i_q*BL +: BL];
    assign b_limb    = b_q[j_q*BL +: BL];
    // product in flight belongs to the pair issued last cycle, tracked by p_vld/sh_q
    assign acc_sum   = acc + (p_vld ? ((2*W)'(prod) << (sh_q * BL)) : '0);

    assign bus.busy      = state != IDLE;
    assign bus.valid     = state == DONE;
    assign bus.outdata_r = res_q;

    multiplier_16x16 u_mul (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .a_i    (a_limb),
        .b_i    (b_limb),
        .p_o    (prod)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? (early_zero ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nx = last_pair ? DRAIN : ISSUE;
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            sh_q  <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
            res_q <= '0;
        end else begin
            p_vld <= state == ISSUE;
            sh_q  <= SW'(i_q) + SW'(j_q);
            if (accept) begin
                a_q   <= bus.indata_a;
                b_q   <= bus.indata_b;
                i_q   <= '0;
                j_q   <= '0;
                acc   <= '0;
                res_q <= '0;
            end else if (state == ISSUE) begin
                j_q <= (j_q == LAST) ? '0 : j_q + 1'b1;
                i_q <= (j_q == LAST) ? i_q + 1'b1 : i_q;
                acc <= acc_sum;
            end else if (state == DRAIN) begin
                acc   <= acc_sum;
                res_q <= acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_multi_block_multiplier.sv
// tb_multi_block_multiplier: randomized run of the multiplier against a cycle-count/product model
module tb_multi_block_multiplier;
    localparam int W   = 64;
    localparam int LAT = 4 * 4 + 2;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    multi_block_multiplier_if #(.W(W)) bus ();
    multi_block_multiplier #(.NUM_BLOCKS(4)) dut (.clk_i(clk_i), .rst_ni(rst_n), .bus(bus));

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int m_left = 0;
    logic [2*W-1:0] m_exp = '0;
    logic [2*W-1:0] m_out = '0;
    logic [2*W-1:0] last_res = '0;

    function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
        int l = LAT;
`ifdef MULT_EARLY_ZERO_EN
        if (a == '0 || b == '0) l = 1;
`endif
        if (a === 'x || b === 'x) l = LAT;
        return l;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = v & (64'hFFFF << (16 * $urandom_range(0, 3)));
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: cycles remaining until the result pulse, 0 when idle
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_out  <= '0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_exp  <= (2*W)'(bus.indata_a) * (2*W)'(bus.indata_b);
                m_left <= lat_of(bus.indata_a, bus.indata_b);
                if (lat_of(bus.indata_a, bus.indata_b) == 1)
                    m_out <= (2*W)'(bus.indata_a) * (2*W)'(bus.indata_b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_out <= m_exp;
        end
    end

    always @(negedge clk_i) begin
        check("busy", (2*W)'(bus.busy), (2*W)'(m_left != 0));
        check("valid", (2*W)'(bus.valid), (2*W)'(m_left == 1));
        if (m_left <= 1) check("outdata", bus.outdata_r, m_out);
        if (bus.valid) begin
            n_valid++;
            last_res = bus.outdata_r;
        end
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (m_left != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        bus.start = 1'b1;
        bus.indata_a = a;
        bus.indata_b = b;
        @(negedge clk_i);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.valid && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
        checks++;
        if (!bus.valid) begin
            errors++;
            $display("FAIL valid_timeout: got no valid_o within %0d cycles want a pulse", lat);
        end
    endtask

    initial begin
        int lat, lat2, v0;
        bus.start = 1'b0;
        bus.indata_a = '0;
        bus.indata_b = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", (2*W)'(bus.busy), '0);
        check("rst_valid", (2*W)'(bus.valid), '0);
        check("rst_out", bus.outdata_r, '0);
        #2 rst_n = 1'b1;
        @(negedge clk_i);

        go(64'h3, 64'h5);
        wait_valid(lat);
        check("small_lat", lat, LAT);
        check("small_res", bus.outdata_r, 128'hF);
        check("small_model", m_exp, 128'hF);

        go('1, '1);
        wait_valid(lat);
        check("max_res", bus.outdata_r, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        go(64'h1234, 64'h10);
        v0 = n_valid;
        for (int c = 2; c <= 24; c++) begin
            @(negedge clk_i);
            bus.start = (c == 5 || c == 17);
            bus.indata_a = rnd();
            bus.indata_b = rnd();
        end
        bus.start = 1'b0;
        check("ignored_starts", n_valid - v0, 1);
        check("ignored_res", last_res, 128'h12340);

        bus.start = 1'b1;
        bus.indata_a = 64'h3;
        bus.indata_b = 64'h5;
        @(negedge clk_i);
        wait_valid(lat);
        check("held_lat", lat, LAT);
        @(negedge clk_i);
        wait_valid(lat2);
        check("held_throughput", lat2, LAT + 1);
        check("held_res", bus.outdata_r, 128'hF);
        bus.start = 1'b0;

        go(64'hDEAD_BEEF, 64'h1234_5678_9ABC);
        repeat (8) @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", (2*W)'(bus.busy), '0);
        check("abort_out", bus.outdata_r, '0);
        repeat (2) @(negedge clk_i);
        #2 rst_n = 1'b1;
        v0 = n_valid;
        repeat (25) @(negedge clk_i);
        check("abort_no_valid", n_valid - v0, 0);
        go(64'h1_0000, 64'h1_0000);
        wait_valid(lat);
        check("after_abort_lat", lat, LAT);
        check("after_abort_res", bus.outdata_r, 128'h1_0000_0000);

        go('0, 64'h1234);
        wait_valid(lat);
`ifdef MULT_EARLY_ZERO_EN
        check("zero_lat", lat, 1);
`else
        check("zero_lat", lat, LAT);
`endif
        check("zero_res", bus.outdata_r, '0);

        v0 = n_valid;
        for (int c = 0; c < 60000 && n_valid - v0 < 1000; c++) begin
            @(negedge clk_i);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.indata_a = rnd();
            bus.indata_b = rnd();
        end
        bus.start = 1'b0;
        check("random_count", (2*W)'(n_valid - v0 >= 1000), 1);
        repeat (25) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
